serial_adder_module: RTL

SERIAL_ADDER_MODULE -- requirements
Module: serial_adder_module

---
 rtl/serial_adder_module.sv | 123 ++++++++++++
 1 files changed

// File: rtl/serial_adder_module.sv
// Bit-serial adder: computes {cout,sum} = a + b + cin one bit per clock,
// LSB first, with a single full-adder slice and a carry flip-flop.
// Optional build macro SERIAL_ADDER_OVERFLOW_EN adds a registered
// two's-complement overflow flag on port ovf.
module serial_adder_module #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVERFLOW_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_psum;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;

   logic             w_load;
   logic             w_lastBit;
   logic             w_fullSum;
   logic             w_fullCarry;

   // A new operation is accepted whenever we are not mid-addition;
   // the final bit slice is the one where the counter reaches WIDTH-1.
   assign w_load      = start && (r_state != SHIFT);
   assign w_lastBit   = (r_state == SHIFT) && (r_cnt == LAST_BIT);
   assign w_fullSum   = r_a[0] ^ r_b[0] ^ r_carry;
   assign w_fullCarry = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));

   assign busy = (r_state == SHIFT);
   assign done = (r_state == DONE);

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: SHIFT runs for exactly WIDTH edges, DONE lasts one cycle.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    w_nextState = start ? SHIFT : IDLE;
         SHIFT:   w_nextState = w_lastBit ? DONE : SHIFT;
         DONE:    w_nextState = start ? SHIFT : IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Operand shift registers, carry flop, partial sum and bit counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_psum  <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
      end else if (w_load) begin
         r_a     <= a;
         r_b     <= b;
         r_psum  <= '0;
         r_carry <= cin;
         r_cnt   <= '0;
      end else if (r_state == SHIFT) begin
         r_a     <= r_a >> 1;
         r_b     <= r_b >> 1;
         r_psum  <= {w_fullSum, r_psum[WIDTH-1:1]};
         r_carry <= w_fullCarry;
         r_cnt   <= r_cnt + CW'(1);
      end
   end

   // Result registers only change on the final bit slice, so they hold the
   // previous answer throughout a new addition.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sum  <= '0;
         cout <= 1'b0;
      end else if (w_lastBit) begin
         sum  <= {w_fullSum, r_psum[WIDTH-1:1]};
         cout <= w_fullCarry;
      end
   end

`ifdef SERIAL_ADDER_OVERFLOW_EN
   // On the final slice r_carry is the carry into the MSB; XOR with the
   // carry out of the MSB gives signed overflow.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovf <= 1'b0;
      end else if (w_lastBit) begin
         ovf <= r_carry ^ w_fullCarry;
      end
   end
`endif

endmodule
